// File: rtl/elevator_pkg.sv
// Shared definitions for the elevator queue add/sub logic and the car controller.
// Provides floor encodings, queue geometry and the car state encoding.
package elevator_pkg;

    localparam int unsigned ENTRY_W     = 2;
    localparam int unsigned QUEUE_DEPTH = 4;
    localparam int unsigned COUNT_W     = 3;

    typedef logic [ENTRY_W-1:0] floor_t;

    localparam floor_t FLOOR_A = 2'd0;
    localparam floor_t FLOOR_B = 2'd1;
    localparam floor_t FLOOR_C = 2'd2;
    localparam floor_t FLOOR_D = 2'd3;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StMove = 2'd1,
        StDoor = 2'd2
    } car_state_e;

    // Neighbouring floor in the given direction; callers guard the A/D ends.
    function automatic floor_t step_floor(input floor_t f, input logic up);
        return up ? (f + floor_t'(1)) : (f - floor_t'(1));
    endfunction

endpackage

// File: rtl/elevator_tick_timer.sv
// Down-counting tick timer shared by the car's MOVE and DOOR phases.
// Ports:
//   clk        - system clock, rising edge
//   rst_n      - synchronous active-low reset, clears the count
//   load_i     - load load_val_i (takes priority over dec_i)
//   load_val_i - value to load
//   dec_i      - decrement by one (no effect at zero)
//   zero_o     - count is zero
module elevator_tick_timer #(
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_i,
    input  logic [CNT_W-1:0] load_val_i,
    input  logic             dec_i,
    output logic             zero_o
);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (dec_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/elevator_car_ctrl.sv
// Elevator car controller: moves the car one floor at a time toward the committed
// queue head, owns the registered floor position and runs the door dwell timer.
// Ports:
//   clk, rst_n       - clock and synchronous active-low reset
//   queue_head       - floor in queue entry 0
//   queue_count      - number of valid queue entries (0..4)
//   stop_at_pos_lvl  - head equals current floor (from the queue sub logic)
//   pos_lvl          - registered current floor
//   moving, dir_up   - car is in MOVE / travel direction (1 = up)
//   door_open        - car is in DOOR
//   arrive           - one-cycle pulse with every pos_lvl update
//   state_dbg        - current state encoding
module elevator_car_ctrl
    import elevator_pkg::*;
#(
    parameter int unsigned FLOOR_TICKS = 50,
    parameter int unsigned DOOR_TICKS  = 100,
    parameter int unsigned CNT_W       = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [ENTRY_W-1:0] queue_head,
    input  logic [COUNT_W-1:0] queue_count,
    input  logic               stop_at_pos_lvl,
    output logic [ENTRY_W-1:0] pos_lvl,
    output logic               moving,
    output logic               dir_up,
    output logic               door_open,
    output logic               arrive,
    output logic [1:0]         state_dbg
);

    localparam logic [CNT_W-1:0] FloorLoad = CNT_W'(FLOOR_TICKS - 1);
    localparam logic [CNT_W-1:0] DoorLoad  = CNT_W'(DOOR_TICKS - 1);

    car_state_e state_q, state_d;
    floor_t     pos_q, pos_d;
    logic       dir_q, dir_d;
    logic       arrive_q, arrive_d;
    logic       moving_q, door_q;

    logic             tmr_load;
    logic [CNT_W-1:0] tmr_val;
    logic             tmr_dec;
    logic             tmr_zero;
    logic             has_req;

    // Counts beyond the queue depth cannot come from a healthy queue; treat as empty.
    assign has_req = (queue_count != '0) && (queue_count <= COUNT_W'(QUEUE_DEPTH));

    elevator_tick_timer #(
        .CNT_W (CNT_W)
    ) u_timer (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_i     (tmr_load),
        .load_val_i (tmr_val),
        .dec_i      (tmr_dec),
        .zero_o     (tmr_zero)
    );

    always_comb begin
        state_d  = state_q;
        pos_d    = pos_q;
        dir_d    = dir_q;
        arrive_d = 1'b0;
        tmr_load = 1'b0;
        tmr_val  = '0;
        tmr_dec  = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (stop_at_pos_lvl) begin
                    state_d  = StDoor;
                    tmr_load = 1'b1;
                    tmr_val  = DoorLoad;
                end else if (has_req && (queue_head != pos_q)) begin
                    state_d  = StMove;
                    tmr_load = 1'b1;
                    tmr_val  = FloorLoad;
                    dir_d    = (queue_head > pos_q);
                end
            end

            // Head/count changes are ignored until the step commits, so reversal
            // only ever happens on a floor boundary.
            StMove: begin
                if (!tmr_zero) begin
                    tmr_dec = 1'b1;
                end else begin
                    state_d = StIdle;
                    if ((dir_q && (pos_q != FLOOR_D)) || (!dir_q && (pos_q != FLOOR_A))) begin
                        pos_d    = step_floor(pos_q, dir_q);
                        arrive_d = 1'b1;
                    end
                end
            end

            StDoor: begin
                if (stop_at_pos_lvl) begin
                    // Repeat request for this floor extends the dwell.
                    tmr_load = 1'b1;
                    tmr_val  = DoorLoad;
                end else if (!tmr_zero) begin
                    tmr_dec = 1'b1;
                end else begin
                    state_d = StIdle;
                end
            end

            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            pos_q    <= FLOOR_A;
            dir_q    <= 1'b0;
            arrive_q <= 1'b0;
            moving_q <= 1'b0;
            door_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            pos_q    <= pos_d;
            dir_q    <= dir_d;
            arrive_q <= arrive_d;
            moving_q <= (state_d == StMove);
            door_q   <= (state_d == StDoor);
        end
    end

    assign pos_lvl   = pos_q;
    assign moving    = moving_q;
    assign dir_up    = dir_q;
    assign door_open = door_q;
    assign arrive    = arrive_q;
    assign state_dbg = state_q;

endmodule

// File: tb/tb_elevator_car_ctrl.sv
// Directed self-checking bench for elevator_car_ctrl (FLOOR_TICKS=4, DOOR_TICKS=3).
module tb_elevator_car_ctrl;
    import elevator_pkg::*;

    localparam int unsigned FT = 4;
    localparam int unsigned DT = 3;

    logic       clk;
    logic       rst_n;
    logic [1:0] head;
    logic [2:0] count;
    logic       stop;
    logic [1:0] pos_lvl;
    logic       moving;
    logic       dir_up;
    logic       door_open;
    logic       arrive;
    logic [1:0] state_dbg;

    int n_assert = 0;
    int n_fail   = 0;

    // Stand-in for the queue sub logic.
    assign stop = (count != 3'd0) && (head == pos_lvl);

    elevator_car_ctrl #(
        .FLOOR_TICKS (FT),
        .DOOR_TICKS  (DT),
        .CNT_W       (8)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .queue_head      (head),
        .queue_count     (count),
        .stop_at_pos_lvl (stop),
        .pos_lvl         (pos_lvl),
        .moving          (moving),
        .dir_up          (dir_up),
        .door_open       (door_open),
        .arrive          (arrive),
        .state_dbg       (state_dbg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Called in IDLE with a request pending toward 'to'; covers FT MOVE cycles + commit.
    task automatic move_floor(input logic [1:0] from, input logic [1:0] to, input logic up);
        for (int i = 0; i < int'(FT); i++) begin
            step();
            chk("mv_moving", {3'b0, moving}, 4'd1);
            chk("mv_dir", {3'b0, dir_up}, {3'b0, up});
            chk("mv_pos", {2'b0, pos_lvl}, {2'b0, from});
            chk("mv_arrive", {3'b0, arrive}, 4'd0);
        end
        step();
        chk("step_pos", {2'b0, pos_lvl}, {2'b0, to});
        chk("step_arrive", {3'b0, arrive}, 4'd1);
        chk("step_state", {2'b0, state_dbg}, 4'd0);
    endtask

    // Called in IDLE at the head floor; drops the request once the door opens.
    task automatic door_cycle();
        step();
        chk("door_open1", {3'b0, door_open}, 4'd1);
        chk("door_state", {2'b0, state_dbg}, 4'd2);
        chk("door_arrive", {3'b0, arrive}, 4'd0);
        count = 3'd0;
        step();
        chk("door_open2", {3'b0, door_open}, 4'd1);
        step();
        chk("door_open3", {3'b0, door_open}, 4'd1);
        chk("door_moving", {3'b0, moving}, 4'd0);
        step();
        chk("door_closed", {3'b0, door_open}, 4'd0);
        chk("door_idle", {2'b0, state_dbg}, 4'd0);
    endtask

    initial begin
        rst_n = 1'b0;
        head  = 2'd0;
        count = 3'd0;

        // 1. Reset with toggling inputs
        step();
        head  = 2'd3;
        count = 3'd1;
        step();
        chk("rst_pos", {2'b0, pos_lvl}, 4'd0);
        chk("rst_moving", {3'b0, moving}, 4'd0);
        chk("rst_door", {3'b0, door_open}, 4'd0);
        chk("rst_arrive", {3'b0, arrive}, 4'd0);
        chk("rst_state", {2'b0, state_dbg}, 4'd0);
        chk("rst_dir", {3'b0, dir_up}, 4'd0);
        count = 3'd0;
        rst_n = 1'b1;
        step();
        chk("park_state", {2'b0, state_dbg}, 4'd0);

        // 2. A -> C, two steps spaced FT+1 cycles
        head  = FLOOR_C;
        count = 3'd1;
        move_floor(FLOOR_A, FLOOR_B, 1'b1);
        move_floor(FLOOR_B, FLOOR_C, 1'b1);

        // 3. Door at C for exactly DT cycles, then parked
        door_cycle();
        for (int i = 0; i < 3; i++) begin
            step();
            chk("parked_pos", {2'b0, pos_lvl}, 4'd2);
            chk("parked_door", {3'b0, door_open}, 4'd0);
            chk("parked_moving", {3'b0, moving}, 4'd0);
        end

        // 4. Dwell extension: repeat request in the 2nd door cycle
        count = 3'd1;
        step();
        chk("ext_door1", {3'b0, door_open}, 4'd1);
        count = 3'd0;
        step();
        chk("ext_door2", {3'b0, door_open}, 4'd1);
        count = 3'd1;
        step();
        chk("ext_door3", {3'b0, door_open}, 4'd1);
        count = 3'd0;
        step();
        chk("ext_door4", {3'b0, door_open}, 4'd1);
        step();
        chk("ext_door5", {3'b0, door_open}, 4'd1);
        step();
        chk("ext_closed", {3'b0, door_open}, 4'd0);
        chk("ext_idle", {2'b0, state_dbg}, 4'd0);

        // 5. Go to B, then head D changed to A during first MOVE cycle
        head  = FLOOR_B;
        count = 3'd1;
        move_floor(FLOOR_C, FLOOR_B, 1'b0);
        door_cycle();
        head  = FLOOR_D;
        count = 3'd1;
        step();
        chk("rev_first_move", {3'b0, moving}, 4'd1);
        chk("rev_first_dir", {3'b0, dir_up}, 4'd1);
        head = FLOOR_A;
        for (int i = 1; i < int'(FT); i++) begin
            step();
            chk("rev_still_up", {3'b0, dir_up}, 4'd1);
            chk("rev_still_moving", {3'b0, moving}, 4'd1);
        end
        step();
        chk("rev_pos_c", {2'b0, pos_lvl}, 4'd2);
        chk("rev_arrive_c", {3'b0, arrive}, 4'd1);
        move_floor(FLOOR_C, FLOOR_B, 1'b0);
        move_floor(FLOOR_B, FLOOR_A, 1'b0);
        door_cycle();
        chk("rev_end_pos", {2'b0, pos_lvl}, 4'd0);

        // 6. Reset mid-step B -> C, then illegal state recovery
        head  = FLOOR_B;
        count = 3'd1;
        move_floor(FLOOR_A, FLOOR_B, 1'b1);
        door_cycle();
        head  = FLOOR_C;
        count = 3'd1;
        step();
        chk("mr_move1", {3'b0, moving}, 4'd1);
        step();
        chk("mr_move2", {3'b0, moving}, 4'd1);
        rst_n = 1'b0;
        step();
        chk("mr_pos", {2'b0, pos_lvl}, 4'd0);
        chk("mr_state", {2'b0, state_dbg}, 4'd0);
        chk("mr_arrive", {3'b0, arrive}, 4'd0);
        chk("mr_moving", {3'b0, moving}, 4'd0);
        count = 3'd0;
        step();
        rst_n = 1'b1;
        step();
        chk("mr_after_pos", {2'b0, pos_lvl}, 4'd0);
        chk("mr_after_arrive", {3'b0, arrive}, 4'd0);

        force dut.state_q = car_state_e'(2'd3);
        #1;
        release dut.state_q;
        step();
        chk("illegal_recover", {2'b0, state_dbg}, 4'd0);
        chk("illegal_moving", {3'b0, moving}, 4'd0);
        chk("illegal_door", {3'b0, door_open}, 4'd0);
        chk("illegal_pos", {2'b0, pos_lvl}, 4'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
